// File: rtl/javk_bus_pkg.sv
// rtl/javk_bus_pkg.sv - shared types and constants for the JAVK bus responder
package javk_bus_pkg;

  localparam int JAVK_DATA_W = 8;
  localparam int JAVK_ADDR_W = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    WRITE
  } resp_state_t;

endpackage

// File: rtl/javk_resp_ram.sv
// rtl/javk_resp_ram.sv - byte-wide responder RAM, synchronous write, asynchronous read
module javk_resp_ram
  import javk_bus_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   addr,
  input  logic [JAVK_DATA_W-1:0] wdata,
  output logic [JAVK_DATA_W-1:0] rdata
);

  logic [JAVK_DATA_W-1:0] mem [2**ADDR_BITS];

  // Contents survive reset on purpose; there is no reset on the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/javk_bus_responder.sv
// rtl/javk_bus_responder.sv - JAVK external-bus target with internal RAM and wait states
// Optional wait-state insertion is built only when JAVK_RESP_WAIT_EN is defined.
module javk_bus_responder
  import javk_bus_pkg::*;
#(
  parameter logic [JAVK_ADDR_W-1:0] BASE        = 16'h8000,
  parameter int                     ADDR_BITS   = 8,
  parameter int                     WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire  [JAVK_DATA_W-1:0] databus,
  input  logic [JAVK_ADDR_W-1:0] addrbus,
  input  logic                   rw,
  input  logic                   as,
  output logic                   rdy,
  output logic                   busy
);

  resp_state_t            state_q, state_d;
  logic [ADDR_BITS-1:0]   off_q;
  logic                   rw_q;
  logic [JAVK_DATA_W-1:0] wdata_q;
  logic [JAVK_DATA_W-1:0] rdata;
  logic                   hit, accept, wait_done, ram_we, drive_en;

  assign hit    = (addrbus[JAVK_ADDR_W-1:ADDR_BITS] == BASE[JAVK_ADDR_W-1:ADDR_BITS]);
  assign accept = (state_q == IDLE) && as && hit;

`ifdef JAVK_RESP_WAIT_EN
  localparam bit USE_WAIT = (WAIT_STATES > 0);
  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= 4'(WAIT_STATES - 1);
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign wait_done = (cnt_q == 4'd0);
`else
  // Without the wait feature the WAIT_STATES setting has no effect.
  localparam bit USE_WAIT = 1'b0 && (WAIT_STATES > 0);
  assign wait_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write data is captured off the bus in the strobe cycle; the CPU may release it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q   <= '0;
      rw_q    <= RW_READ;
      wdata_q <= '0;
    end else if (accept) begin
      off_q <= addrbus[ADDR_BITS-1:0];
      rw_q  <= rw;
      if (rw == RW_WRITE) begin
        wdata_q <= databus;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (USE_WAIT) state_d = WAIT;
          else          state_d = (rw == RW_READ) ? READ : WRITE;
        end
      end
      WAIT: begin
        if (wait_done) state_d = (rw_q == RW_READ) ? READ : WRITE;
      end
      READ:    state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A reset landing on the WRITE cycle must abandon the store.
  always_comb begin
    rdy      = 1'b0;
    busy     = (state_q != IDLE);
    drive_en = 1'b0;
    ram_we   = 1'b0;
    case (state_q)
      READ: begin
        rdy      = 1'b1;
        drive_en = 1'b1;
      end
      WRITE: begin
        rdy    = 1'b1;
        ram_we = !rst;
      end
      default: ;
    endcase
  end

  assign databus = drive_en ? rdata : 'z;

  javk_resp_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (off_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );

endmodule
